jtag_bitbang_conditioner: RTL and testbench
===========================================

# jtag_bitbang_conditioner

Conditions the FTDI bit-bang JTAG lines (DTR→TCK, RTS→TMS, TXD→TDI) before they reach the GPIO JTAG pins, and returns TDO to FTDI RXD. Each input is synchronised into `clk_25mhz`, glitch-filtered, and re-registered, with TCK skewed one cycle behind TDI/TMS. A shadow IEEE 1149.1 TAP state machine and a TCK edge counter run from the conditioned signals and feed the LEDs and debug logic. The block sits between the FTDI pins and the `gp`/`gn` JTAG outputs in the passthrough top level.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per async input (≥2).
- `FILTER_LEN`, 3: consecutive cycles a synchronised input must differ from its filtered value before the filtered value follows (≥1).
- `TCK_CNT_WIDTH`, 16: width of `tck_count`.

- `clk_25mhz`  in  1  system clock, 25 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `ftdi_ndtr`  in  1  async, host TCK.
- `ftdi_nrts`  in  1  async, host TMS.
- `ftdi_txd`  in  1  async, host TDI.
- `jtag_tdo`  in  1  async, target TDO.
- `jtag_tck`  out  1  conditioned TCK to pin.
- `jtag_tms`  out  1  conditioned TMS to pin.
- `jtag_tdi`  out  1  conditioned TDI to pin.
- `ftdi_rxd`  out  1  synchronised TDO to host.
- `tck_rise`  out  1  one-cycle pulse, same cycle `jtag_tck` goes 0→1.
- `tap_state`  out  4  shadow TAP state.
- `tck_count`  out  TCK_CNT_WIDTH  count of TCK rising edges, wraps.

## Operation
- Sync: each of the 4 async inputs passes through SYNC_STAGES flops. The synchroniser flops reset to the same value as their channel's output reset value.
- Filter, per channel TCK/TMS/TDI: counter `cnt`, filtered value `filt`.
  - If synced ≠ filt and cnt = FILTER_LEN−1: filt ← synced, cnt ← 0.
  - Else if synced ≠ filt: cnt ← cnt+1.
  - Else: cnt ← 0.
  - A pulse shorter than FILTER_LEN cycles is discarded.
- Output registers:
  - `jtag_tdi` ← filt_tdi; `jtag_tms` ← filt_tms.
  - `jtag_tck` ← a one-cycle-delayed copy of filt_tck. TDI/TMS therefore lead TCK by ≥1 cycle (40 ns) of setup.
- `ftdi_rxd` is the last synchroniser flop of `jtag_tdo`. It is not filtered.
- `tck_rise` = `jtag_tck` next-value high and current value low, registered so it coincides with the first high cycle of `jtag_tck`.
- TAP FSM advances in the cycle after `tck_rise`, using the `jtag_tms` value sampled with `tck_rise`. Transitions are standard 1149.1. Encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- `tck_count` increments by 1 in the cycle after `tck_rise`. It wraps from 2^TCK_CNT_WIDTH−1 to 0.
- Reset values:
  - `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `ftdi_rxd`=1, `tck_rise`=0.
  - `tap_state`=F, `tck_count`=0.
  - All filter counters 0, filt_tck=0, filt_tms=1, filt_tdi=0.
- Reset mid-operation: every register returns to its reset value on the next edge, regardless of FSM state or filter progress. No TCK edge is emitted during or because of reset release if `ftdi_ndtr` is low.
- Five consecutive TCK rises with TMS=1 reach TLR from any state.

## Timing
- Pin change at cycle 0 (held stable):
  - synced at SYNC_STAGES;
  - filt at SYNC_STAGES+FILTER_LEN;
  - `jtag_tdi`/`jtag_tms` at SYNC_STAGES+FILTER_LEN+1 (defaults: 6);
  - `jtag_tck` and `tck_rise` at SYNC_STAGES+FILTER_LEN+2 (defaults: 7);
  - `tap_state` and `tck_count` update at +8.
- `ftdi_rxd` latency: SYNC_STAGES cycles.
- Maximum usable TCK rate: each level must be held ≥FILTER_LEN cycles. The host bit-bang rate (≤3 MHz) satisfies this at defaults.
- Simultaneous TMS and TCK pin change: TMS reaches `jtag_tms` one cycle before `jtag_tck` rises. The FSM uses the new TMS.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs → `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `ftdi_rxd`=1, `tap_state`=F, `tck_count`=0, `tck_rise`=0.
- Latency:
  - `ftdi_txd` 0→1 at cycle 0 → `jtag_tdi` high at cycle 6.
  - `ftdi_ndtr` 0→1 at cycle 0 → `jtag_tck` high and a single `tck_rise` at cycle 7; `tck_count`=1 at cycle 8.
  - `jtag_tdo` 1→0 at cycle 0 → `ftdi_rxd` low at cycle 2.
- Glitch: `ftdi_ndtr` high for 2 cycles then low → `jtag_tck` stays 0, no `tck_rise`, `tck_count` unchanged.
- TAP walk:
  - From TLR, clock TMS=0,1,0,0 → `tap_state` F→C→7→6→2.
  - Then TMS=1 ×5 → F; `tck_count`=9.
  - Then TMS=0,1,1,0,0 → C,7,4,E,A.
- Reset in Shift-IR (A) with `tck_count`=14 → next cycle `tap_state`=F, `tck_count`=0, `jtag_tms`=1.
- Wrap: TCK_CNT_WIDTH=4, 17 TCK rises → `tck_count` reads 15 after rise 15, 0 after rise 16, 1 after rise 17.

Source files
------------

// File: rtl/jtag_bitbang_conditioner.sv
// Conditions FTDI bit-bang JTAG lines (sync, glitch filter, TCK skew) and returns TDO.
// Latency: TDI/TMS pin->out SYNC_STAGES+FILTER_LEN+1, TCK +2, TDO->RXD SYNC_STAGES.
// Backpressure: none; free-running pipeline sampled every clk_25mhz cycle.
module jtag_bitbang_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 3,
  parameter int TCK_CNT_WIDTH = 16
) (
  input  logic                     clk_25mhz,
  input  logic                     reset,
  input  logic                     ftdi_ndtr,
  input  logic                     ftdi_nrts,
  input  logic                     ftdi_txd,
  input  logic                     jtag_tdo,
  output logic                     jtag_tck,
  output logic                     jtag_tms,
  output logic                     jtag_tdi,
  output logic                     ftdi_rxd,
  output logic                     tck_rise,
  output logic [3:0]               tap_state,
  output logic [TCK_CNT_WIDTH-1:0] tck_count
);

  // Filter counter must hold 0..FILTER_LEN-1; keep at least one bit.
  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  // Channel index for the filtered lines: 0 = TCK, 1 = TMS, 2 = TDI.
  localparam logic [2:0] FILT_RST = 3'b010;

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  logic [SYNC_STAGES-1:0] sync_tck;
  logic [SYNC_STAGES-1:0] sync_tms;
  logic [SYNC_STAGES-1:0] sync_tdi;
  logic [SYNC_STAGES-1:0] sync_tdo;
  logic [2:0]             synced;
  logic [2:0]             filt;
  logic [CNT_W-1:0]       cnt [3];
  logic                   tck_dly;
  tap_state_t             state_q;
  tap_state_t             state_d;

  // Synchroniser chains; each resets to its channel's idle output level so
  // reset release never manufactures an edge.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      sync_tck <= '0;
      sync_tms <= '1;
      sync_tdi <= '0;
      sync_tdo <= '1;
    end else begin
      sync_tck <= {sync_tck[SYNC_STAGES-2:0], ftdi_ndtr};
      sync_tms <= {sync_tms[SYNC_STAGES-2:0], ftdi_nrts};
      sync_tdi <= {sync_tdi[SYNC_STAGES-2:0], ftdi_txd};
      sync_tdo <= {sync_tdo[SYNC_STAGES-2:0], jtag_tdo};
    end
  end

  assign synced = {sync_tdi[SYNC_STAGES-1], sync_tms[SYNC_STAGES-1], sync_tck[SYNC_STAGES-1]};

  // Glitch filter: a channel follows its synced input only after the input
  // has disagreed with it for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      filt <= FILT_RST;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (synced[i] != filt[i]) begin
          if (cnt[i] == CNT_MAX) begin
            filt[i] <= synced[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Output registers; TCK gets one extra stage so TDI/TMS lead it by a cycle.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      jtag_tms <= 1'b1;
      jtag_tdi <= 1'b0;
      tck_dly  <= 1'b0;
      jtag_tck <= 1'b0;
      tck_rise <= 1'b0;
    end else begin
      jtag_tms <= filt[1];
      jtag_tdi <= filt[2];
      tck_dly  <= filt[0];
      jtag_tck <= tck_dly;
      tck_rise <= tck_dly & ~jtag_tck;
    end
  end

  assign ftdi_rxd = sync_tdo[SYNC_STAGES-1];

  // Shadow TAP state register.
  always_ff @(posedge clk_25mhz) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  // Standard 1149.1 transitions, taken once per conditioned TCK rise using
  // the TMS value present on the pin during that rise.
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = jtag_tms ? TLR    : RTI;
        RTI:     state_d = jtag_tms ? SEL_DR : RTI;
        SEL_DR:  state_d = jtag_tms ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = jtag_tms ? EX1_DR : SH_DR;
        SH_DR:   state_d = jtag_tms ? EX1_DR : SH_DR;
        EX1_DR:  state_d = jtag_tms ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = jtag_tms ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = jtag_tms ? UPD_DR : SH_DR;
        UPD_DR:  state_d = jtag_tms ? SEL_DR : RTI;
        SEL_IR:  state_d = jtag_tms ? TLR    : CAP_IR;
        CAP_IR:  state_d = jtag_tms ? EX1_IR : SH_IR;
        SH_IR:   state_d = jtag_tms ? EX1_IR : SH_IR;
        EX1_IR:  state_d = jtag_tms ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = jtag_tms ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = jtag_tms ? UPD_IR : SH_IR;
        UPD_IR:  state_d = jtag_tms ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  assign tap_state = state_q;

  // Free-running TCK rise counter; wraps naturally.
  always_ff @(posedge clk_25mhz) begin
    if (reset)         tck_count <= '0;
    else if (tck_rise) tck_count <= tck_count + TCK_CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_jtag_bitbang_conditioner.sv
// Bench for jtag_bitbang_conditioner: directed steps plus randomized pins
// against a timing-equation reference model evaluated every cycle.
module tb_jtag_bitbang_conditioner;
  localparam int S    = 2;
  localparam int F    = 3;
  localparam int NMAX = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ftdi_ndtr = 1'b0, ftdi_nrts = 1'b1, ftdi_txd = 1'b0, jtag_tdo = 1'b1;

  logic jtag_tck, jtag_tms, jtag_tdi, ftdi_rxd, tck_rise;
  logic [3:0]  tap_state;
  logic [15:0] tck_count;
  logic jtag_tck4, jtag_tms4, jtag_tdi4, ftdi_rxd4, tck_rise4;
  logic [3:0]  tap_state4;
  logic [3:0]  tck_count4;

  jtag_bitbang_conditioner #(.SYNC_STAGES(S), .FILTER_LEN(F), .TCK_CNT_WIDTH(16)) dut (
    .clk_25mhz(clk), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
    .ftdi_txd(ftdi_txd), .jtag_tdo(jtag_tdo), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .ftdi_rxd(ftdi_rxd), .tck_rise(tck_rise),
    .tap_state(tap_state), .tck_count(tck_count));

  jtag_bitbang_conditioner #(.SYNC_STAGES(S), .FILTER_LEN(F), .TCK_CNT_WIDTH(4)) dut4 (
    .clk_25mhz(clk), .reset(reset), .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts),
    .ftdi_txd(ftdi_txd), .jtag_tdo(jtag_tdo), .jtag_tck(jtag_tck4), .jtag_tms(jtag_tms4),
    .jtag_tdi(jtag_tdi4), .ftdi_rxd(ftdi_rxd4), .tck_rise(tck_rise4),
    .tap_state(tap_state4), .tck_count(tck_count4));

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: history arrays indexed by clock edge number.
  int  n = 0;
  int  r_last = 0;
  bit  pin   [4][NMAX];   // 0 tck, 1 tms, 2 tdi, 3 tdo as sampled at edge k
  bit  rs    [NMAX];
  bit  fl    [3][NMAX];   // filtered level after edge k
  bit  o_tck [NMAX];
  bit  o_tms [NMAX];
  bit  o_tdi [NMAX];
  bit  m_rise[NMAX];
  logic [3:0] m_st [NMAX];
  int  m_cnt [NMAX];

  // IEEE 1149.1 next-state tables, one nibble per current state.
  logic [63:0] nxt0 = 64'hCACC_BABA_62CE_3232;
  logic [63:0] nxt1 = 64'hF977_89DD_417F_0155;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input bit tms);
    return tms ? nxt1[4*s +: 4] : nxt0[4*s +: 4];
  endfunction

  function automatic bit rst_val(input int ch);
    return (ch == 1 || ch == 3);
  endfunction

  // Synchronised level of a channel after edge k.
  function automatic bit synced(input int ch, input int k);
    if (k - r_last < S || k - S + 1 < 0) return rst_val(ch);
    return pin[ch][k - S + 1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, update the model and compare every output.
  task automatic step();
    pin[0][n+1] = ftdi_ndtr;
    pin[1][n+1] = ftdi_nrts;
    pin[2][n+1] = ftdi_txd;
    pin[3][n+1] = jtag_tdo;
    rs[n+1]     = reset;
    @(posedge clk);
    #1;
    n++;
    if (rs[n]) begin
      r_last = n;
      for (int c = 0; c < 3; c++) fl[c][n] = rst_val(c);
      o_tck[n] = 1'b0; o_tms[n] = 1'b1; o_tdi[n] = 1'b0;
      m_rise[n] = 1'b0; m_st[n] = 4'hF; m_cnt[n] = 0;
    end else begin
      // A filtered line flips only after F consecutive disagreeing samples.
      for (int c = 0; c < 3; c++) begin
        bit all_diff = 1'b1;
        for (int k = 1; k <= F; k++)
          if (synced(c, n - k) == fl[c][n-1]) all_diff = 1'b0;
        fl[c][n] = all_diff ? ~fl[c][n-1] : fl[c][n-1];
      end
      o_tms[n]  = fl[1][n-1];
      o_tdi[n]  = fl[2][n-1];
      o_tck[n]  = (n - 2 < r_last) ? 1'b0 : fl[0][n-2];
      m_rise[n] = o_tck[n] & ~o_tck[n-1];
      m_st[n]   = m_rise[n-1] ? tap_next(m_st[n-1], o_tms[n-1]) : m_st[n-1];
      m_cnt[n]  = m_rise[n-1] ? m_cnt[n-1] + 1 : m_cnt[n-1];
    end
    chk("tck",   jtag_tck,  o_tck[n]);
    chk("tms",   jtag_tms,  o_tms[n]);
    chk("tdi",   jtag_tdi,  o_tdi[n]);
    chk("rxd",   ftdi_rxd,  synced(3, n));
    chk("rise",  tck_rise,  m_rise[n]);
    chk("state", tap_state, m_st[n]);
    chk("count", tck_count, m_cnt[n] % 65536);
    chk("count4", tck_count4, m_cnt[n] % 16);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // One full TCK period with a given TMS; the state update lands on the last edge.
  task automatic tck_pulse(input bit tms);
    ftdi_nrts = tms;
    ftdi_ndtr = 1'b1;
    steps(4);
    ftdi_ndtr = 1'b0;
    steps(4);
  endtask

  initial begin
    logic [3:0] walk_exp [5];
    logic [3:0] ir_exp [5];
    bit  walk_tms [4];
    bit  ir_tms [5];
    int  hold [4];
    walk_tms = '{0, 1, 0, 0};
    walk_exp = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h0};
    ir_tms   = '{0, 1, 1, 0, 0};
    ir_exp   = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};

    // Reset for two cycles with random pin levels.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {ftdi_ndtr, ftdi_nrts, ftdi_txd, jtag_tdo} = 4'($urandom);
      step();
    end
    chk("rst_tck", jtag_tck, 0);
    chk("rst_tms", jtag_tms, 1);
    chk("rst_tdi", jtag_tdi, 0);
    chk("rst_rxd", ftdi_rxd, 1);
    chk("rst_state", tap_state, 4'hF);
    chk("rst_count", tck_count, 0);
    chk("rst_rise", tck_rise, 0);

    ftdi_ndtr = 1'b0; ftdi_nrts = 1'b1; ftdi_txd = 1'b0; jtag_tdo = 1'b1;
    reset = 1'b0;
    steps(10);

    // TDI latency.
    ftdi_txd = 1'b1;
    steps(5);
    chk("tdi_lat5", jtag_tdi, 0);
    step();
    chk("tdi_lat6", jtag_tdi, 1);

    // TCK latency and single rise.
    ftdi_ndtr = 1'b1;
    steps(6);
    chk("tck_lat6", jtag_tck, 0);
    step();
    chk("tck_lat7", jtag_tck, 1);
    chk("rise_lat7", tck_rise, 1);
    chk("cnt_lat7", tck_count, 0);
    step();
    chk("rise_lat8", tck_rise, 0);
    chk("cnt_lat8", tck_count, 1);
    ftdi_ndtr = 1'b0;
    steps(10);

    // TDO return latency.
    jtag_tdo = 1'b0;
    step();
    chk("rxd_lat1", ftdi_rxd, 1);
    step();
    chk("rxd_lat2", ftdi_rxd, 0);
    jtag_tdo = 1'b1;
    steps(4);

    // Two-cycle TCK glitch must vanish.
    ftdi_ndtr = 1'b1;
    steps(2);
    ftdi_ndtr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("glitch_tck", jtag_tck, 0);
      chk("glitch_rise", tck_rise, 0);
    end
    chk("glitch_cnt", tck_count, 1);

    // TAP walk from a clean reset.
    reset = 1'b1; step(); reset = 1'b0; steps(4);
    for (int i = 0; i < 4; i++) begin
      tck_pulse(walk_tms[i]);
      chk("walk", tap_state, walk_exp[i]);
    end
    for (int i = 0; i < 5; i++) tck_pulse(1'b1);
    chk("walk_tlr", tap_state, 4'hF);
    chk("walk_cnt", tck_count, 9);
    for (int i = 0; i < 5; i++) begin
      tck_pulse(ir_tms[i]);
      chk("walk_ir", tap_state, ir_exp[i]);
    end
    chk("shir_cnt", tck_count, 14);

    // Reset while in Shift-IR.
    ftdi_nrts = 1'b0;
    reset = 1'b1;
    step();
    chk("midrst_state", tap_state, 4'hF);
    chk("midrst_cnt", tck_count, 0);
    chk("midrst_tms", jtag_tms, 1);
    reset = 1'b0;
    steps(4);

    // Counter wrap on the 4-bit instance.
    for (int i = 1; i <= 17; i++) begin
      tck_pulse(1'b1);
      if (i == 15) chk("wrap15", tck_count4, 15);
      if (i == 16) chk("wrap16", tck_count4, 0);
      if (i == 17) chk("wrap17", tck_count4, 1);
    end
    chk("nowrap17", tck_count, 17);

    // Randomized pins with random hold lengths (includes sub-filter glitches)
    // and an occasional reset pulse.
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int i = 0; i < 1200; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          bit v;
          v = 1'($urandom);
          case (c)
            0: ftdi_ndtr = v;
            1: ftdi_nrts = v;
            2: ftdi_txd  = v;
            default: jtag_tdo = v;
          endcase
          hold[c] = $urandom_range(1, 7);
        end
        hold[c]--;
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    steps(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
